// File: rtl/input_evt_pkg.sv
// Shared definitions for the input event arbiter.
//   arb_state_t              : arbiter FSM encoding (ST_IDLE=0, ST_PRESENT=1)
//   clog2_w()                : ceil(log2(value)), never below 1, for port and counter widths
//   DEFAULT_DEBOUNCE_CYCLES  : stable-cycle count used when the top is not overridden
package input_evt_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced input channel: synchronizer, stability counter, edge pulses.
//   sysclk, reset_n : clock and asynchronous active-low reset
//   raw             : asynchronous board input
//   level           : debounced stable level
//   rise_pulse      : one-cycle pulse, combinational, high on the edge where level goes 0->1
//   fall_pulse      : one-cycle pulse, combinational, high on the edge where level goes 1->0
module debounce_chan
  import input_evt_pkg::*;
#(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = clog2_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  sync_meta #(.WIDTH(1), .STAGES(STAGES)) u_sync (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .d       (raw),
    .q       (s)
  );

  // Accept on the edge where the counter already holds DEBOUNCE_CYCLES-1:
  // together with that edge the new level has been seen DEBOUNCE_CYCLES times.
  assign accept     = (s != level) && (cnt == CNT_LAST);
  assign rise_pulse = accept &  s;
  assign fall_pulse = accept & ~s;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (accept) begin
      level <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_meta.sv
// Multi-flop metastability synchronizer.
//   sysclk  : destination clock
//   reset_n : asynchronous active-low reset, clears every stage
//   d       : asynchronous input bits
//   q       : synchronized copy, STAGES edges behind d
module sync_meta #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p [STAGES];

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/input_event_arbiter.sv
// Debounced multi-input event front end with round-robin serialization.
// Optional build macro: INPUT_EVENT_RELEASE_EN -- when defined, debounced
// falling edges also raise events and event_level reports press/release.
//   sysclk, reset_n : clock and asynchronous active-low reset
//   async_in        : raw asynchronous inputs, one per channel
//   level_out       : debounced stable levels
//   event_valid     : an event is being presented
//   event_ready     : consumer accepts the presented event
//   event_idx       : channel of the presented event
//   event_level     : stable level of that channel captured at grant
//   overrun         : sticky per-channel lost-event flags
//   overrun_clr     : one-cycle pulse clearing all overrun flags
module input_event_arbiter
  import input_evt_pkg::*;
#(
  parameter  int CHANNELS        = 4,
  parameter  int STAGES          = 2,
  parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int IDX_W           = clog2_w(CHANNELS)
) (
  input  logic                sysclk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [IDX_W-1:0]    event_idx,
  output logic                event_level,
  output logic [CHANNELS-1:0] overrun,
  input  logic                overrun_clr
);

  logic [CHANNELS-1:0] rise, fall, ev;
  logic [CHANNELS-1:0] pending, clr_mask, ovr_set;
  logic [IDX_W-1:0]    last_grant, sel;
  logic                any, grant_level;
  arb_state_t          state;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .sysclk     (sysclk),
      .reset_n    (reset_n),
      .raw        (async_in[i]),
      .level      (level_out[i]),
      .rise_pulse (rise[i]),
      .fall_pulse (fall[i])
    );
  end

`ifdef INPUT_EVENT_RELEASE_EN
  assign ev          = rise | fall;
  assign grant_level = level_out[sel];
`else
  // rise and fall never coincide on a channel, so masking leaves rise intact.
  assign ev          = rise & ~fall;
  assign grant_level = 1'b1;
`endif

  // Round-robin search starting just after last_grant. The loop runs from the
  // farthest offset down so the nearest pending channel is the last assignment.
  always_comb begin
    int c;
    c   = 0;
    sel = '0;
    any = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      c = (int'(last_grant) + k) % CHANNELS;
      if (pending[c]) begin
        sel = IDX_W'(c);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    if (state == ST_IDLE && any) clr_mask[sel] = 1'b1;
  end

  // A new edge on a channel being granted this cycle is a fresh event, not a loss.
  assign ovr_set = ev & pending & ~clr_mask;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      overrun     <= '0;
      event_valid <= 1'b0;
      event_idx   <= '0;
      event_level <= 1'b0;
      last_grant  <= IDX_W'(CHANNELS - 1);
    end else begin
      pending <= (pending & ~clr_mask) | ev;
      overrun <= (overrun & ~{CHANNELS{overrun_clr}}) | ovr_set;
      case (state)
        ST_IDLE: begin
          if (any) begin
            event_idx   <= sel;
            event_level <= grant_level;
            event_valid <= 1'b1;
            state       <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (event_ready) begin
            event_valid <= 1'b0;
            last_grant  <= event_idx;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_event_arbiter.sv
// Directed bench for input_event_arbiter (CHANNELS=4, STAGES=2, DEBOUNCE_CYCLES=4),
// default build (release events disabled).
module tb_input_event_arbiter;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic [3:0] async_in;
  logic [3:0] level_out;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_idx;
  logic       event_level;
  logic [3:0] overrun;
  logic       overrun_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int bad;

  input_event_arbiter #(
    .CHANNELS        (4),
    .STAGES          (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .async_in    (async_in),
    .level_out   (level_out),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_idx   (event_idx),
    .event_level (event_level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Advance while ch1 is being presented; any drop of valid or idx change is counted.
  task automatic stall(input int n);
    repeat (n) begin
      tick();
      if (event_valid !== 1'b1 || event_idx !== 2'd1) bad++;
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      tick();
      if (event_valid !== 1'b0) bad++;
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    async_in    = 4'b0000;
    event_ready = 1'b0;
    overrun_clr = 1'b0;
    tick(2);
    check("rst_level_out",   32'(level_out),   32'h0);
    check("rst_event_valid", 32'(event_valid), 32'h0);
    check("rst_event_idx",   32'(event_idx),   32'h0);
    check("rst_event_level", 32'(event_level), 32'h0);
    check("rst_overrun",     32'(overrun),     32'h0);

    reset_n = 1'b1;
    bad = 0;
    quiet(20);
    check("idle_no_event", 32'(bad), 32'h0);

    // Single press on ch2 with ready held high
    event_ready = 1'b1;
    async_in[2] = 1'b1;
    tick(5);
    check("ch2_level_edge5", 32'(level_out), 32'h0);
    tick();
    check("ch2_level_edge6", 32'(level_out), 32'h4);
    check("ch2_valid_edge6", 32'(event_valid), 32'h0);
    tick();
    check("ch2_valid_edge7", 32'(event_valid), 32'h1);
    check("ch2_idx_edge7",   32'(event_idx),   32'h2);
    check("ch2_level_ev",    32'(event_level), 32'h1);
    tick();
    check("ch2_valid_after_hs", 32'(event_valid), 32'h0);
    async_in[2] = 1'b0;
    bad = 0;
    quiet(10);
    check("ch2_release_no_event", 32'(bad), 32'h0);
    check("ch2_release_level",    32'(level_out), 32'h0);

    // Two short pulses on ch1: neither may be accepted
    for (int p = 0; p < 2; p++) begin
      async_in[1] = 1'b1;
      tick(3);
      async_in[1] = 1'b0;
      bad = 0;
      repeat (10) begin
        tick();
        if (event_valid !== 1'b0 || level_out !== 4'b0000) bad++;
      end
      check($sformatf("glitch_reject_%0d", p), 32'(bad), 32'h0);
    end

    // Simultaneous ch0+ch3 after reset: ch0 first
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    async_in = 4'b1001;
    tick(6);
    check("dual_level", 32'(level_out), 32'h9);
    tick();
    check("rr1_valid_a", 32'(event_valid), 32'h1);
    check("rr1_idx_a",   32'(event_idx),   32'h0);
    tick();
    check("rr1_gap", 32'(event_valid), 32'h0);
    tick();
    check("rr1_valid_b", 32'(event_valid), 32'h1);
    check("rr1_idx_b",   32'(event_idx),   32'h3);
    tick();
    check("rr1_done", 32'(event_valid), 32'h0);
    async_in = 4'b0000;
    tick(10);

    // Make ch0 the last grant, then press both again: ch3 first
    async_in[0] = 1'b1;
    tick(7);
    check("solo0_idx", 32'(event_idx), 32'h0);
    tick();
    async_in[0] = 1'b0;
    tick(10);
    async_in = 4'b1001;
    tick(7);
    check("rr2_valid_a", 32'(event_valid), 32'h1);
    check("rr2_idx_a",   32'(event_idx),   32'h3);
    tick(2);
    check("rr2_valid_b", 32'(event_valid), 32'h1);
    check("rr2_idx_b",   32'(event_idx),   32'h0);
    tick();
    check("rr2_done", 32'(event_valid), 32'h0);
    async_in = 4'b0000;
    tick(10);

    // Stall on ch1: second press pends, third press overruns
    event_ready = 1'b0;
    async_in[1] = 1'b1;
    tick(7);
    check("stall_valid", 32'(event_valid), 32'h1);
    check("stall_idx",   32'(event_idx),   32'h1);
    bad = 0;
    async_in[1] = 1'b0;
    stall(7);
    async_in[1] = 1'b1;
    stall(7);
    check("ovr_after_second", 32'(overrun), 32'h0);
    async_in[1] = 1'b0;
    stall(7);
    async_in[1] = 1'b1;
    stall(6);
    check("ovr_after_third", 32'(overrun), 32'h2);
    check("stall_stable", 32'(bad), 32'h0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    event_ready = 1'b1;
    tick();
    check("stall_hs", 32'(event_valid), 32'h0);
    tick();
    check("pend_valid", 32'(event_valid), 32'h1);
    check("pend_idx",   32'(event_idx),   32'h1);
    tick();
    check("pend_done", 32'(event_valid), 32'h0);
    bad = 0;
    quiet(4);
    check("lost_event_absent", 32'(bad), 32'h0);
    async_in[1] = 1'b0;
    tick(10);

    // Reset mid-PRESENT: outputs drop without a clock edge
    event_ready = 1'b0;
    async_in[2] = 1'b1;
    tick(7);
    check("pre_rst_valid", 32'(event_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(event_valid), 32'h0);
    check("async_rst_idx",   32'(event_idx),   32'h0);
    check("async_rst_level", 32'(level_out),   32'h0);
    async_in = 4'b0000;
    tick(2);
    reset_n = 1'b1;
    event_ready = 1'b1;
    bad = 0;
    quiet(20);
    check("no_stale_event", 32'(bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
